shift_in_register: RTL and testbench

- Serial-in/parallel-out register; the receive-side counterpart of the team's loadable parallel register/shifter.
- Collects WIDTH serial bits framed by a start strobe, then presents the assembled word on a held output with a valid/ack handshake.
- The shifter and the output holding register form a double buffer, so the next frame can shift in while the previous word waits for ack.
- Sits between a serial link front end and a word-wide consumer.

---
 rtl/shift_in_register.sv | 124 ++++++++++++
 tb/tb_shift_in_register.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_in_register.sv
// Serial-in/parallel-out register: frames WIDTH serial bits on a start strobe and
// hands the assembled word to a consumer through a held dout with valid/ack.
module shift_in_register #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sin_valid,
   input  logic                       sin,
   input  logic                       start,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ack,
   output logic                       busy,
   output logic [$clog2(WIDTH):0]     bit_count,
   output logic                       overrun,
   output logic                       frame_err,
   input  logic                       clr_err
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shifter_q, shifter_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] shift_in;
   logic             complete;
   logic             ovr_set;
   logic             ferr_set;

   always_comb begin
      if (MSB_FIRST) shift_in = {shifter_q[WIDTH-2:0], sin};
      else           shift_in = {sin, shifter_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         shifter_q    <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shifter_q    <= shifter_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Framing FSM: a start always opens a new frame, even mid-frame.
   always_comb begin
      state_d   = state_q;
      shifter_d = shifter_q;
      cnt_d     = cnt_q;
      complete  = 1'b0;
      ferr_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sin_valid && start) begin
               shifter_d = shift_in;
               cnt_d     = CW'(1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               shifter_d = shift_in;
               if (start) begin
                  ferr_set = 1'b1;
                  cnt_d    = CW'(1);
               end else if (cnt_q == CW'(WIDTH - 1)) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output holding register; ack in the completion cycle frees the slot.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      ovr_set      = 1'b0;
      if (complete) begin
         if (!dout_valid_q || dout_ack) begin
            dout_d       = shift_in;
            dout_valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (dout_ack) begin
         dout_valid_d = 1'b0;
      end
      overrun_d   = ovr_set  | (overrun_q   & ~clr_err);
      frame_err_d = ferr_set | (frame_err_q & ~clr_err);
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (state_q == SHIFT);
   assign bit_count  = cnt_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_shift_in_register.sv
// Bench for shift_in_register: MSB-first and LSB-first instances share one stimulus
// stream and are compared against a queue-based frame model plus fixed vectors.
module tb_shift_in_register;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic clk = 1'b0;
   logic reset = 1'b0, sin_valid = 1'b0, sin = 1'b0, start = 1'b0;
   logic dout_ack = 1'b0, clr_err = 1'b0;

   logic [W-1:0]  dout_m, dout_l;
   logic          valid_m, valid_l, busy_m, busy_l;
   logic [CW-1:0] cnt_m, cnt_l;
   logic          ovr_m, ovr_l, fe_m, fe_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_in_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin(sin), .start(start),
      .dout(dout_m), .dout_valid(valid_m), .dout_ack(dout_ack), .busy(busy_m),
      .bit_count(cnt_m), .overrun(ovr_m), .frame_err(fe_m), .clr_err(clr_err));

   shift_in_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin(sin), .start(start),
      .dout(dout_l), .dout_valid(valid_l), .dout_ack(dout_ack), .busy(busy_l),
      .bit_count(cnt_l), .overrun(ovr_l), .frame_err(fe_l), .clr_err(clr_err));

   // Reference model: the current frame is simply the list of bits received so far.
   int           q[$];
   logic [W-1:0] m_dm = '0, m_dl = '0;
   bit           m_v = 0, m_ovr = 0, m_fe = 0;

   function automatic logic [W-1:0] pack(input int b[$], input bit msb);
      logic [W-1:0] r = '0;
      for (int i = 0; i < b.size(); i++) begin
         if (msb) r[W-1-i] = b[i][0];
         else     r[i]     = b[i][0];
      end
      return r;
   endfunction

   task automatic model_step();
      bit done = 0;
      bit ovs  = 0;
      bit fes  = 0;
      int w[$];
      if (reset) begin
         q.delete();
         m_dm = '0; m_dl = '0; m_v = 0; m_ovr = 0; m_fe = 0;
      end else begin
         if (sin_valid) begin
            if (start) begin
               if (q.size() != 0) fes = 1;
               q.delete();
               q.push_back(int'(sin));
            end else if (q.size() != 0) begin
               q.push_back(int'(sin));
               if (q.size() == W) begin
                  done = 1;
                  w = q;
                  q.delete();
               end
            end
         end
         if (done) begin
            if (!m_v || dout_ack) begin
               m_dm = pack(w, 1'b1);
               m_dl = pack(w, 1'b0);
               m_v  = 1;
            end else begin
               ovs = 1;
            end
         end else if (dout_ack) begin
            m_v = 0;
         end
         m_ovr = ovs | (m_ovr & !clr_err);
         m_fe  = fes | (m_fe & !clr_err);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("m.dout", 32'(dout_m), 32'(m_dm));
      chk("l.dout", 32'(dout_l), 32'(m_dl));
      chk("m.valid", 32'(valid_m), 32'(m_v));
      chk("l.valid", 32'(valid_l), 32'(m_v));
      chk("m.busy", 32'(busy_m), 32'(q.size() != 0));
      chk("l.busy", 32'(busy_l), 32'(q.size() != 0));
      chk("m.bit_count", 32'(cnt_m), 32'(q.size()));
      chk("l.bit_count", 32'(cnt_l), 32'(q.size()));
      chk("m.overrun", 32'(ovr_m), 32'(m_ovr));
      chk("l.overrun", 32'(ovr_l), 32'(m_ovr));
      chk("m.frame_err", 32'(fe_m), 32'(m_fe));
      chk("l.frame_err", 32'(fe_l), 32'(m_fe));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
   task automatic cyc(input bit sv, input bit s, input bit st, input bit ack,
                      input bit clr, input bit rst);
      sin_valid = sv; sin = s; start = st; dout_ack = ack; clr_err = clr; reset = rst;
      @(posedge clk);
      model_step();
      #1;
      chk_model();
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit ack_last, input int max_gap);
      for (int i = 0; i < W; i++) begin
         if (i > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) cyc(0, 0, 0, 0, 0, 0);
         cyc(1, w[W-1-i], i == 0, ack_last && (i == W - 1), 0, 0);
      end
   endtask

   typedef struct {
      bit           s;
      bit           st;
      bit           busy;
      int           cnt;
      bit           valid;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1, 1, 1, 1, 0};
      vecs[1] = '{0, 0, 1, 2, 0};
      vecs[2] = '{1, 0, 1, 3, 0};
      vecs[3] = '{1, 0, 1, 4, 0};
      vecs[4] = '{0, 0, 1, 5, 0};
      vecs[5] = '{0, 0, 1, 6, 0};
      vecs[6] = '{1, 0, 1, 7, 0};
      vecs[7] = '{0, 0, 0, 0, 1};

      #2;
      cyc(0, 0, 0, 0, 0, 1);
      chk("reset.dout", 32'(dout_m), 32'h0);
      chk("reset.valid", 32'(valid_m), 32'h0);
      chk("reset.busy", 32'(busy_m), 32'h0);
      chk("reset.cnt", 32'(cnt_m), 32'h0);
      chk("reset.flags", 32'({ovr_m, fe_m}), 32'h0);

      // Frame 1,0,1,1,0,0,1,0 : B2 MSB-first, 4D LSB-first
      foreach (vecs[i]) begin
         cyc(1, vecs[i].s, vecs[i].st, 0, 0, 0);
         chk("vec.busy", 32'(busy_m), 32'(vecs[i].busy));
         chk("vec.cnt", 32'(cnt_m), 32'(vecs[i].cnt));
         chk("vec.valid", 32'(valid_m), 32'(vecs[i].valid));
      end
      chk("frame.msb", 32'(dout_m), 32'hB2);
      chk("frame.lsb", 32'(dout_l), 32'h4D);
      cyc(0, 0, 0, 1, 0, 0);
      chk("ack.valid", 32'(valid_l), 32'h0);
      chk("ack.hold", 32'(dout_l), 32'h4D);

      // Back-to-back without ack, then with ack on the last bit
      send_word(8'hA5, 0, 0);
      send_word(8'h3C, 0, 0);
      chk("ovr.dout", 32'(dout_m), 32'hA5);
      chk("ovr.flag", 32'(ovr_m), 32'h1);
      cyc(0, 0, 0, 1, 1, 0);
      chk("ovr.clr", 32'(ovr_m), 32'h0);
      send_word(8'hA5, 0, 0);
      send_word(8'h3C, 1, 0);
      chk("ackovr.dout", 32'(dout_m), 32'h3C);
      chk("ackovr.valid", 32'(valid_m), 32'h1);
      chk("ackovr.ovr", 32'(ovr_m), 32'h0);

      // Restart after three bits
      cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("part.cnt", 32'(cnt_m), 32'h3);
      send_word(8'hFF, 0, 0);
      chk("ferr.flag", 32'(fe_m), 32'h1);
      chk("ferr.dout", 32'(dout_m), 32'hFF);
      cyc(0, 0, 0, 0, 1, 0);
      chk("ferr.clr", 32'(fe_m), 32'h0);

      // Idle noise then a gapped frame
      cyc(0, 0, 0, 1, 0, 0);
      repeat (3) cyc(1, 1'($urandom), 0, 0, 0, 0);
      chk("idle.cnt", 32'(cnt_m), 32'h0);
      chk("idle.busy", 32'(busy_m), 32'h0);
      send_word(8'h81, 0, 3);
      chk("gap.dout", 32'(dout_m), 32'h81);
      chk("gap.valid", 32'(valid_m), 32'h1);

      // Reset mid-frame with a word pending
      cyc(1, 0, 1, 0, 0, 0);
      repeat (4) cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 1);
      chk("rst.dout", 32'(dout_m), 32'h0);
      chk("rst.valid", 32'(valid_m), 32'h0);
      chk("rst.busy", 32'(busy_m), 32'h0);
      chk("rst.cnt", 32'(cnt_m), 32'h0);
      send_word(8'h5A, 0, 0);
      chk("post.dout", 32'(dout_m), 32'h5A);

      // Random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 199) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
